// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and
// feeds a one-deep IF/ID register backed by a one-entry hold buffer.
module fetch_unit #(
    parameter logic [7:0]  RESET_PC = 8'h00,
    parameter int unsigned INSTR_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         PC_out,
    input  logic [1:0]         BS_out,
    output logic [7:0]         PC_value,
    output logic               imem_req,
    output logic [7:0]         imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] ir_out,
    output logic [7:0]         ir_pc,
    output logic               ir_valid,
    input  logic               id_stall
);

    typedef enum logic [1:0] {IDLE, REQ, BUF, DRAIN} state_t;

    state_t               state;
    logic [7:0]           pc_reg;
    logic [INSTR_W-1:0]   hold_data;
    logic [7:0]           hold_pc;

    logic                 consume;
    logic                 redirect;
    logic                 ir_free;
    logic [7:0]           pc_inc;

    assign consume  = ir_valid & ~id_stall;
    assign redirect = consume & (BS_out != 2'b00);
    assign ir_free  = ~ir_valid | ~id_stall;
    assign pc_inc   = pc_reg + 8'd1;
    assign PC_value = pc_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc_reg    <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            ir_out    <= '0;
            ir_pc     <= '0;
            ir_valid  <= 1'b0;
            hold_data <= '0;
            hold_pc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state     <= REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= pc_reg;
                end
                REQ: begin
                    // In REQ imem_addr always equals pc_reg, so pc_inc is the next address.
                    if (redirect) begin
                        pc_reg   <= PC_out;
                        ir_valid <= 1'b0;
                        if (imem_ack) begin
                            imem_addr <= PC_out;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (imem_ack && ir_free) begin
                        ir_out    <= imem_data;
                        ir_pc     <= imem_addr;
                        ir_valid  <= 1'b1;
                        pc_reg    <= pc_inc;
                        imem_addr <= pc_inc;
                    end else if (imem_ack) begin
                        hold_data <= imem_data;
                        hold_pc   <= imem_addr;
                        pc_reg    <= pc_inc;
                        imem_req  <= 1'b0;
                        state     <= BUF;
                    end else if (consume) begin
                        ir_valid <= 1'b0;
                    end
                end
                BUF: begin
                    if (redirect) begin
                        pc_reg    <= PC_out;
                        imem_addr <= PC_out;
                        ir_valid  <= 1'b0;
                        imem_req  <= 1'b1;
                        state     <= REQ;
                    end else if (consume) begin
                        ir_out    <= hold_data;
                        ir_pc     <= hold_pc;
                        ir_valid  <= 1'b1;
                        imem_addr <= pc_reg;
                        imem_req  <= 1'b1;
                        state     <= REQ;
                    end
                end
                DRAIN: begin
                    if (redirect) begin
                        pc_reg   <= PC_out;
                        ir_valid <= 1'b0;
                    end else if (imem_ack) begin
                        imem_addr <= pc_reg;
                        state     <= REQ;
                    end else if (consume) begin
                        ir_valid <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 8-bit RISC core. It owns the program counter and presents it to the next-PC multiplexer as the sequential candidate. It accepts the multiplexer's selected address on a taken branch or jump, and runs a req/ack handshake to instruction memory. Fetched words go into a one-deep IF/ID instruction register, with a one-entry hold buffer so decode stalls never lose a word.

## Interface
Parameters:
- RESET_PC, 8'h00, first fetch address after reset
- INSTR_W, 16, instruction word width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- PC_out  in  8  next-PC from the mux; used only on redirect
- BS_out  in  2  mux selector; 2'b00 = sequential, any other value = redirect
- PC_value  out  8  current fetch pointer pc_reg; sequential candidate to the mux
- imem_req  out  1  fetch request; held until ack
- imem_addr  out  8  request address; stable while imem_req=1
- imem_ack  in  1  memory accepts request and returns imem_data this cycle
- imem_data  in  INSTR_W  instruction word, valid when imem_ack=1
- ir_out  out  INSTR_W  instruction to decode
- ir_pc  out  8  address of ir_out
- ir_valid  out  1  ir_out holds a live instruction
- id_stall  in  1  decode cannot take ir_out this cycle

## Operation
Definitions:
- consume = ir_valid & ~id_stall
- redirect = consume & (BS_out != 2'b00); BS_out is ignored when consume=0

States:
- IDLE: one cycle after reset. imem_req=0. Next state: REQ with imem_addr=pc_reg.
- REQ: imem_req=1. Waits for imem_ack.
- BUF: a word is held in the buffer. imem_req=0.
- DRAIN: imem_req=1 on a stale address. The returned word is discarded.

Transitions (priority top to bottom):
- rst: state IDLE; pc_reg=RESET_PC; ir_valid=0; ir_out=0; ir_pc=0; imem_addr=RESET_PC; buffer empty.
- redirect in REQ with imem_ack: the returned word is dropped. pc_reg and imem_addr take PC_out. Stay REQ.
- redirect in REQ without imem_ack: pc_reg takes PC_out. Go DRAIN; imem_addr unchanged.
- redirect in BUF: buffer discarded. pc_reg and imem_addr take PC_out. Go REQ.
- redirect in DRAIN: pc_reg takes PC_out (last redirect wins). Stay DRAIN.
- In every redirect case, ir_valid goes to 0.
- REQ, imem_ack, IR free (ir_valid=0 or consume):
  - IR takes imem_data; ir_pc takes imem_addr; ir_valid=1.
  - pc_reg takes pc_reg+1; imem_addr takes the new pc_reg. Stay REQ.
- REQ, imem_ack, IR occupied and stalled:
  - Word and address go into the buffer; pc_reg takes pc_reg+1. Go BUF.
- BUF with consume (no redirect): buffer moves into IR; ir_valid=1; imem_addr takes pc_reg. Go REQ.
- DRAIN with imem_ack: data dropped; imem_addr takes pc_reg. Go REQ.
- Otherwise: hold all state. ir_valid goes to 0 when consume occurs and nothing is loaded.

Arithmetic: pc_reg+1 is modulo 256, so 8'hFF wraps to 8'h00.

## Timing
- Reset release at cycle 0: IDLE. First imem_req=1 at cycle 1 with imem_addr=RESET_PC.
- Zero-wait memory (ack in the same cycle as req): ir_valid rises the cycle after ack. Sustained rate is one instruction per cycle while id_stall=0.
- Redirect with pending ack: the word is dropped and the request continues until acked. The target request is issued the cycle after the stale ack.
- Redirect penalty with zero-wait memory: redirect at cycle n, target request at n+1, target instruction in IR at n+2.
- imem_addr never changes while imem_req=1 and imem_ack=0.
- All outputs are registered or derived only from registers (PC_value=pc_reg). There is no combinational path from any input to any output.
- rst asserted mid-request abandons the request. imem_req is 0 in the cycle following the reset edge.

## Test plan
- Reset, zero-wait memory, id_stall=0 -> imem_addr 00,01,02,... one per cycle; ir_pc trails by one cycle; ir_valid=1 from cycle 2.
- Run to 8'hFF sequentially -> next imem_addr 8'h00; PC_value wraps to 0.
- id_stall=1 for 3 cycles while an ack arrives -> state BUF, imem_req=0, ir_out unchanged. Stall release -> buffered word enters IR, then fetch resumes at the next address; no word lost or duplicated.
- Sequence: ir_pc=05 consumed with BS_out=2'b10 and PC_out=8'h40 while the request at 06 waits 2 cycles for ack -> DRAIN; the word for 06 never appears in IR; next imem_addr=40; ir_pc=40 follows.
- Redirect in BUF with PC_out=8'h20 -> buffer discarded; ir_valid=0 next cycle; imem_addr=20.
- rst pulsed while imem_req=1 and no ack -> next cycle imem_req=0, ir_valid=0, PC_value=RESET_PC.
